// File: rtl/i2c_init_sequencer.sv
// Walks an external write table after a start pulse and feeds one
// write transfer per entry into the I2C master, retrying on timeout.
module i2c_init_sequencer #(
    parameter int NUM_CMDS   = 16,
    parameter int IDX_W      = 8,
    parameter int START_TMO  = 1024,
    parameter int DONE_TMO   = 65536,
    parameter int GAP_CYCLES = 256,
    parameter int MAX_RETRY  = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    output logic [IDX_W-1:0] cmd_index,
    input  logic [6:0]       rom_addr,
    input  logic [7:0]       rom_data,
    output logic             send,
    output logic [6:0]       addr,
    output logic [7:0]       data,
    output logic             rw,
    input  logic             busy,
    output logic             seq_busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index
);

    localparam int TMO_MAX = (START_TMO > DONE_TMO) ? START_TMO : DONE_TMO;
    localparam int TW = $clog2(TMO_MAX + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0]    START_LAST = TW'(START_TMO - 1);
    localparam logic [TW-1:0]    DONE_LAST  = TW'(DONE_TMO - 1);
    localparam logic [GW-1:0]    GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_CMDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REQ, S_RUN, S_RETRY, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic             busy_m_q, busy_s_q;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             redo_q, redo_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;

    // State, counters, latched table entry and busy synchroniser
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_m_q  <= 1'b0;
            busy_s_q  <= 1'b0;
            tmo_q     <= '0;
            gap_q     <= '0;
            retry_q   <= '0;
            redo_q    <= 1'b0;
            idx_q     <= '0;
            err_idx_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_m_q  <= busy;
            busy_s_q  <= busy_m_q;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            retry_q   <= retry_d;
            redo_q    <= redo_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    // Next state and counter updates; redo marks a gap that precedes a retry
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        retry_d   = retry_q;
        redo_d    = redo_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    idx_d   = '0;
                    retry_d = '0;
                    redo_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                addr_d  = rom_addr;
                data_d  = rom_data;
                tmo_d   = '0;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (busy_s_q) begin
                    tmo_d   = '0;
                    state_d = S_RUN;
                end else if (tmo_q == START_LAST) begin
                    state_d = S_RETRY;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!busy_s_q) begin
                    gap_d   = '0;
                    redo_d  = 1'b0;
                    state_d = S_GAP;
                end else if (tmo_q == DONE_LAST) begin
                    state_d = S_RETRY;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RETRY: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 1'b1;
                    redo_d  = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    err_idx_d = idx_q;
                    state_d   = S_ERROR;
                end
            end
            S_GAP: begin
                if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + 1'b1;
                end else if (redo_q) begin
                    tmo_d   = '0;
                    state_d = S_REQ;
                end else begin
                    retry_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; reset gates send without waiting a clock
    always_comb begin
        send      = (state_q == S_REQ) && !reset;
        seq_busy  = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
        done      = (state_q == S_DONE);
        error     = (state_q == S_ERROR);
        rw        = 1'b0;
        addr      = addr_q;
        data      = data_q;
        cmd_index = idx_q;
        err_index = err_idx_q;
    end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench for i2c_init_sequencer: a table-level model predicts
// every send attempt and the final outcome; a monitor compares them.
module tb_i2c_init_sequencer;

    localparam int N    = 4;
    localparam int IW   = 3;
    localparam int STMO = 32;
    localparam int DTMO = 300;
    localparam int GAP  = 16;
    localparam int MR   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy = 1'b0;
    logic [IW-1:0] cmd_index, err_index;
    logic [6:0]    rom_addr, addr;
    logic [7:0]    rom_data, data;
    logic          send, rw, seq_busy, done, error;

    logic [6:0] rom_a [N];
    logic [7:0] rom_d [N];

    assign rom_addr = (cmd_index < IW'(N)) ? rom_a[cmd_index] : 7'h7f;
    assign rom_data = (cmd_index < IW'(N)) ? rom_d[cmd_index] : 8'hff;

    always #10 clk = ~clk;

    i2c_init_sequencer #(
        .NUM_CMDS(N), .IDX_W(IW), .START_TMO(STMO),
        .DONE_TMO(DTMO), .GAP_CYCLES(GAP), .MAX_RETRY(MR)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .start(start),
        .cmd_index(cmd_index), .rom_addr(rom_addr), .rom_data(rom_data),
        .send(send), .addr(addr), .data(data), .rw(rw), .busy(busy),
        .seq_busy(seq_busy), .done(done), .error(error),
        .err_index(err_index)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef enum int {M_OK, M_NOBUSY, M_HANG} mode_t;
    typedef struct {
        int         idx;
        logic [6:0] a;
        logic [7:0] d;
        mode_t      m;
    } att_t;
    typedef struct {
        bit ok;
        int idx;
    } out_t;

    att_t  exp_att[$];
    out_t  exp_out[$];
    mode_t plan[$];
    int    fails [N];
    bit    in_reset = 1'b0;
    bit    release_hang = 1'b0;

    task automatic push_att(input int i, input mode_t m);
        att_t e;
        e.idx = i;
        e.a   = rom_a[i];
        e.d   = rom_d[i];
        e.m   = m;
        exp_att.push_back(e);
        plan.push_back(m);
    endtask

    task automatic push_out(input bit ok, input int i);
        out_t o;
        o.ok  = ok;
        o.idx = i;
        exp_out.push_back(o);
    endtask

    // Table-level model: entry i fails fails[i] times; an entry fails for
    // good once its failures exceed MR, and a hung entry never recovers.
    task automatic build(input int hang_at);
        int nf;
        for (int i = 0; i < N; i++) begin
            if (i == hang_at) begin
                for (int a = 0; a <= MR; a++) push_att(i, M_HANG);
                push_out(1'b0, i);
                return;
            end
            nf = (fails[i] > MR + 1) ? MR + 1 : fails[i];
            for (int a = 0; a < nf; a++) push_att(i, M_NOBUSY);
            if (fails[i] > MR) begin
                push_out(1'b0, i);
                return;
            end
            push_att(i, M_OK);
        end
        push_out(1'b1, 0);
    endtask

    // Behavioural I2C master driven by the plan queue
    initial begin
        int    st;
        int    cnt;
        bit    psend;
        mode_t m;
        st = 0;
        cnt = 0;
        psend = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (in_reset || release_hang) begin
                busy = 1'b0;
                st = 0;
            end else if (send && !psend) begin
                m = (plan.size() > 0) ? plan.pop_front() : M_OK;
                case (m)
                    M_OK: begin
                        st = 1;
                        cnt = $urandom_range(1, 10);
                    end
                    M_HANG: begin
                        st = 3;
                        busy = 1'b1;
                    end
                    default: st = 0;
                endcase
            end else begin
                case (st)
                    1: begin
                        cnt = cnt - 1;
                        if (cnt == 0) begin
                            busy = 1'b1;
                            st = 2;
                            cnt = $urandom_range(5, 60);
                        end
                    end
                    2: begin
                        cnt = cnt - 1;
                        if (cnt == 0) begin
                            busy = 1'b0;
                            st = 0;
                        end
                    end
                    default: ;
                endcase
            end
            psend = send;
        end
    end

    // Monitor: pops the scoreboard on every send rise and sequence end
    initial begin
        bit         psend, pseq;
        int         width, lastfall, cyc;
        logic [6:0] sa;
        logic [7:0] sd;
        att_t       e;
        out_t       o;
        mode_t      cur;
        psend = 1'b0;
        pseq = 1'b0;
        width = 0;
        lastfall = -1;
        cyc = 0;
        sa = '0;
        sd = '0;
        cur = M_OK;
        forever begin
            @(negedge clk);
            cyc++;
            if (!in_reset) begin
                if (seq_busy && !pseq) lastfall = -1;
                if (send && !psend) begin
                    check("idx_range", 32'(cmd_index <= IW'(N - 1)), 1);
                    if (exp_att.size() == 0) begin
                        check("unexpected_send", 1, 0);
                    end else begin
                        e = exp_att.pop_front();
                        check("send_idx", 32'(cmd_index), e.idx);
                        check("send_addr", 32'(addr), 32'(e.a));
                        check("send_data", 32'(data), 32'(e.d));
                        check("send_rw", 32'(rw), 0);
                        cur = e.m;
                    end
                    if (lastfall >= 0)
                        check("gap_len", 32'((cyc - lastfall) >= GAP), 1);
                    width = 0;
                    sa = addr;
                    sd = data;
                end
                if (send) begin
                    width++;
                    if (addr !== sa || data !== sd)
                        check("addr_data_stable", 0, 1);
                    if (!seq_busy) check("send_outside_seq", 0, 1);
                end
                if (!send && psend) begin
                    if (cur == M_NOBUSY) check("req_width", width, STMO);
                    lastfall = cyc;
                end
                if (!seq_busy && pseq) begin
                    if (exp_out.size() == 0) begin
                        check("unexpected_end", 1, 0);
                    end else begin
                        o = exp_out.pop_front();
                        check("end_done", 32'(done), 32'(o.ok));
                        check("end_error", 32'(error), 32'(!o.ok));
                        if (!o.ok)
                            check("err_index", 32'(err_index), o.idx);
                    end
                end
            end
            psend = send;
            pseq = seq_busy;
        end
    end

    task automatic apply_reset(input bit mid);
        in_reset = 1'b1;
        exp_att.delete();
        exp_out.delete();
        plan.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        if (mid) check("send_drop_same_cycle", 32'(send), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_send", 32'(send), 0);
        check("rst_cmd_index", 32'(cmd_index), 0);
        check("rst_seq_busy", 32'(seq_busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        if (!mid) begin
            check("rst_err_index", 32'(err_index), 0);
            check("rst_addr", 32'(addr), 0);
            check("rst_data", 32'(data), 0);
            check("rst_rw", 32'(rw), 0);
        end
        repeat (3) @(posedge clk);
        #1 in_reset = 1'b0;
    endtask

    task automatic pulse_start_checked();
        @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check("lat_cycle1_send", 32'(send), 0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("lat_cycle2_send", 32'(send), 0);
        check("seq_busy_after_start", 32'(seq_busy), 1);
        check("done_cleared", 32'(done), 0);
        check("error_cleared", 32'(error), 0);
        @(negedge clk);
        check("lat_cycle3_send", 32'(send), 1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (seq_busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (seq_busy) check("idle_timeout", 0, 1);
        #1;
    endtask

    task automatic run(input int hang_at, input bit poke);
        build(hang_at);
        pulse_start_checked();
        if (poke) begin
            repeat (40) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_idle(20000);
        check("attempts_left", exp_att.size(), 0);
        check("outcomes_left", exp_out.size(), 0);
    endtask

    task automatic clear_fails();
        for (int i = 0; i < N; i++) fails[i] = 0;
    endtask

    task automatic new_rom();
        for (int i = 0; i < N; i++) begin
            rom_a[i] = 7'($urandom);
            rom_d[i] = 8'($urandom);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        new_rom();
        clear_fails();
        apply_reset(1'b0);

        run(-1, 1'b0);

        fails[0] = MR + 1;
        run(-1, 1'b0);

        clear_fails();
        new_rom();
        run(1, 1'b0);
        @(posedge clk);
        #1 release_hang = 1'b1;
        repeat (6) @(posedge clk);
        #1 release_hang = 1'b0;

        fails[2] = 1;
        fails[3] = MR;
        run(-1, 1'b0);

        clear_fails();
        new_rom();
        build(-1);
        pulse_start_checked();
        n = 0;
        while (!(cmd_index == IW'(1) && busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reached_entry1_run", 32'(busy), 1);
        repeat (3) @(posedge clk);
        apply_reset(1'b1);
        run(-1, 1'b0);

        run(-1, 1'b1);
        repeat (5) @(negedge clk);
        check("done_sticky", 32'(done), 1);
        run(-1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            new_rom();
            for (int i = 0; i < N; i++)
                fails[i] = ($urandom_range(0, 99) < 70) ? 0
                         : $urandom_range(1, MR + 1);
            run(-1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
